// File: rtl/cursor_region_decoder_pkg.sv
// Shared definitions for the cursor hit-test unit.
//   Region codes driven on value_choice, and the hit-test FSM state encoding.
package cursor_region_decoder_pkg;

  localparam logic [1:0] REG_BLANK = 2'd0;
  localparam logic [1:0] REG_BOARD = 2'd1;
  localparam logic [1:0] REG_BTN0  = 2'd2;
  localparam logic [1:0] REG_BTN1  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_CLASS = 2'd2
  } state_t;

endpackage

// File: rtl/cursor_region_decoder_seq_udiv.sv
// Restoring shift-subtract unsigned divider, one quotient bit per cycle.
//   clk, rst          : clock, synchronous active-high reset (drops any division in flight)
//   start             : load dividend/divisor, begin a W-cycle division
//   dividend, divisor : W-bit unsigned operands
//   done              : high during the final iteration cycle; results are
//                       stable from the following cycle until the next start
//   quotient, remainder : W-bit results
module seq_udiv #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic          busy;
  logic [CW-1:0] cnt;
  logic [W:0]    trial;
  logic [W:0]    diff;

  // Quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while quotient bits enter at the LSB.
  assign trial = {remainder, quotient[W-1]};
  assign diff  = trial - {1'b0, divisor};
  assign done  = busy && (cnt == CW'(W-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt       <= '0;
      quotient  <= dividend;
      remainder <= '0;
    end else if (busy) begin
      if (trial >= {1'b0, divisor}) begin
        remainder <= diff[W-1:0];
        quotient  <= {quotient[W-2:0], 1'b1};
      end else begin
        remainder <= trial[W-1:0];
        quotient  <= {quotient[W-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/cursor_region_decoder.sv
// Cursor hit-test and key-event unit.
//   Maps a cursor pixel to the nearest board intersection or a screen button
//   and classifies the region; latches key events into a held interrupt.
//   clk, rst_p              : clock, synchronous active-high reset
//   x_i, y_i, btn_i, page_i : sample, taken on valid_i while ready_o=1
//   ready_o                 : engine idle
//   seat_x_o, seat_y_o, vga_btn_o, value_choice : classification result
//   out_valid_o             : one-cycle pulse when the result updates
//   btn_o, btn_valid_o, btn_ack_i, overrun_o    : key interrupt path
module cursor_region_decoder
  import cursor_region_decoder_pkg::*;
#(
  parameter int COORD_W     = 12,
  parameter int BTN_W       = 8,
  parameter int SEAT_W      = 4,
  parameter int BOARD_N     = 15,
  parameter int GRID_X0     = 200,
  parameter int GRID_Y0     = 40,
  parameter int PITCH       = 28,
  parameter int NUM_VBTN    = 4,
  parameter int VBTN_IDX_W  = 4,
  parameter int VBTN_X0     = 700,
  parameter int VBTN_Y0     = 100,
  parameter int VBTN_WIDTH  = 80,
  parameter int VBTN_HEIGHT = 40,
  parameter int VBTN_PITCH  = 60
) (
  input  logic                  clk,
  input  logic                  rst_p,
  input  logic [COORD_W-1:0]    x_i,
  input  logic [COORD_W-1:0]    y_i,
  input  logic [BTN_W-1:0]      btn_i,
  input  logic                  valid_i,
  input  logic                  page_i,
  output logic                  ready_o,
  output logic [SEAT_W-1:0]     seat_x_o,
  output logic [SEAT_W-1:0]     seat_y_o,
  output logic [VBTN_IDX_W-1:0] vga_btn_o,
  output logic [1:0]            value_choice,
  output logic                  out_valid_o,
  output logic [BTN_W-1:0]      btn_o,
  output logic                  btn_valid_o,
  input  logic                  btn_ack_i,
  output logic                  overrun_o
);

  localparam int OW = COORD_W + 1;

  state_t state, state_nx;
  logic   accept;

  // Signed offsets; bit COORD_W set means the cursor lies before the origin.
  logic [OW-1:0] ox_in, oy_in, by_in;
  logic          ox_neg, oy_neg, by_neg, xband, page;
  logic          bx_in;

  logic [COORD_W-1:0] qx, rx, qy, ry, qb, rb;
  logic               done_x, done_y, done_b;
  logic               board_hit, btn_hit;
  logic [BTN_W-1:0]   btn_prev;
  logic               key_event;

  assign accept = valid_i && (state == ST_IDLE);

  assign ox_in = {1'b0, x_i} + OW'(PITCH / 2) - OW'(GRID_X0);
  assign oy_in = {1'b0, y_i} + OW'(PITCH / 2) - OW'(GRID_Y0);
  assign by_in = {1'b0, y_i} - OW'(VBTN_Y0);
  assign bx_in = (x_i >= COORD_W'(VBTN_X0)) && (x_i < COORD_W'(VBTN_X0 + VBTN_WIDTH));

  seq_udiv #(.W(COORD_W)) u_div_x (
    .clk(clk), .rst(rst_p), .start(accept), .dividend(ox_in[COORD_W-1:0]),
    .divisor(COORD_W'(PITCH)), .done(done_x), .quotient(qx), .remainder(rx));
  seq_udiv #(.W(COORD_W)) u_div_y (
    .clk(clk), .rst(rst_p), .start(accept), .dividend(oy_in[COORD_W-1:0]),
    .divisor(COORD_W'(PITCH)), .done(done_y), .quotient(qy), .remainder(ry));
  seq_udiv #(.W(COORD_W)) u_div_b (
    .clk(clk), .rst(rst_p), .start(accept), .dividend(by_in[COORD_W-1:0]),
    .divisor(COORD_W'(VBTN_PITCH)), .done(done_b), .quotient(qb), .remainder(rb));

  always_ff @(posedge clk) begin
    if (rst_p) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // The three dividers start together and run in lockstep.
  always_comb begin
    state_nx = state;
    ready_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_nx = ST_DIV;
      end
      ST_DIV:   if (done_x && done_y && done_b) state_nx = ST_CLASS;
      ST_CLASS: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      ox_neg <= 1'b0;
      oy_neg <= 1'b0;
      by_neg <= 1'b0;
      xband  <= 1'b0;
      page   <= 1'b0;
    end else if (accept) begin
      ox_neg <= ox_in[COORD_W];
      oy_neg <= oy_in[COORD_W];
      by_neg <= by_in[COORD_W];
      xband  <= bx_in;
      page   <= page_i;
    end
  end

  assign board_hit = !ox_neg && !oy_neg &&
                     (qx < COORD_W'(BOARD_N)) && (qy < COORD_W'(BOARD_N));
  // rx/ry only matter to the divider itself; rb rejects the inter-button gap.
  assign btn_hit   = xband && !by_neg && (qb < COORD_W'(NUM_VBTN)) &&
                     (rb < COORD_W'(VBTN_HEIGHT));

  always_ff @(posedge clk) begin
    if (rst_p) begin
      seat_x_o     <= '0;
      seat_y_o     <= '0;
      vga_btn_o    <= '0;
      value_choice <= REG_BLANK;
      out_valid_o  <= 1'b0;
    end else begin
      out_valid_o <= (state == ST_CLASS);
      if (state == ST_CLASS) begin
        seat_x_o     <= '0;
        seat_y_o     <= '0;
        vga_btn_o    <= '0;
        value_choice <= REG_BLANK;
        if (board_hit) begin
          seat_x_o     <= qx[SEAT_W-1:0];
          seat_y_o     <= qy[SEAT_W-1:0];
          value_choice <= REG_BOARD;
        end else if (btn_hit) begin
          vga_btn_o    <= qb[VBTN_IDX_W-1:0];
          value_choice <= page ? REG_BTN1 : REG_BTN0;
        end
      end
    end
  end

  // Key path acts on the accepted sample directly, independent of the divide.
  assign key_event = accept && (btn_i != btn_prev) && (btn_i != '0);

  always_ff @(posedge clk) begin
    if (rst_p) begin
      btn_prev    <= '0;
      btn_o       <= '0;
      btn_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (accept) btn_prev <= btn_i;
      if (key_event) begin
        btn_o       <= btn_i;
        btn_valid_o <= 1'b1;
        if (btn_valid_o && !btn_ack_i) overrun_o <= 1'b1;
      end else if (btn_ack_i) begin
        btn_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cursor_region_decoder.sv
module tb_cursor_region_decoder;

  logic        clk = 1'b0;
  logic        rst_p;
  logic [11:0] x_i, y_i;
  logic [7:0]  btn_i;
  logic        valid_i, page_i, btn_ack_i;
  logic        ready_o, out_valid_o, btn_valid_o, overrun_o;
  logic [3:0]  seat_x_o, seat_y_o, vga_btn_o;
  logic [1:0]  value_choice;
  logic [7:0]  btn_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cursor_region_decoder dut (
    .clk(clk), .rst_p(rst_p), .x_i(x_i), .y_i(y_i), .btn_i(btn_i),
    .valid_i(valid_i), .page_i(page_i), .ready_o(ready_o),
    .seat_x_o(seat_x_o), .seat_y_o(seat_y_o), .vga_btn_o(vga_btn_o),
    .value_choice(value_choice), .out_valid_o(out_valid_o), .btn_o(btn_o),
    .btn_valid_o(btn_valid_o), .btn_ack_i(btn_ack_i), .overrun_o(overrun_o));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample, check the busy window and the result pulse at cycle 14.
  // inj raises a stray valid_i (btn 0x44, x=10) while the engine is busy.
  task automatic sample(input int x, input int y, input int btn, input bit pg,
                        input bit ack, input bit inj);
    int busy_bad;
    @(negedge clk);
    x_i = 12'(x); y_i = 12'(y); btn_i = 8'(btn); page_i = pg;
    valid_i = 1'b1; btn_ack_i = ack;
    @(posedge clk);
    busy_bad = 0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) begin valid_i = 1'b0; btn_ack_i = 1'b0; end
      if (inj && k == 3) begin valid_i = 1'b1; btn_i = 8'h44; x_i = 12'd10; end
      if (inj && k == 4) valid_i = 1'b0;
      if (ready_o !== 1'b0 || out_valid_o !== 1'b0) busy_bad++;
    end
    chk("busy_window", busy_bad, 0);
    @(negedge clk);
    chk("out_valid_pulse", {ready_o, out_valid_o}, 2'b11);
  endtask

  initial begin
    int ov_seen;
    rst_p = 1'b1; x_i = '0; y_i = '0; btn_i = '0; valid_i = 1'b0;
    page_i = 1'b0; btn_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_p = 1'b0;
    chk("reset_ready", ready_o, 1);
    chk("reset_outs", {out_valid_o, value_choice, seat_x_o, seat_y_o, vga_btn_o}, 0);
    chk("reset_key", {btn_valid_o, overrun_o, btn_o}, 0);

    sample(230, 100, 0, 0, 0, 0);
    chk("board_1_2", {value_choice, seat_x_o, seat_y_o, vga_btn_o}, {2'd1, 4'd1, 4'd2, 4'd0});
    @(negedge clk);
    chk("pulse_one_cycle", out_valid_o, 0);
    chk("outs_held", {value_choice, seat_x_o, seat_y_o}, {2'd1, 4'd1, 4'd2});

    sample(720, 230, 0, 1, 0, 0);
    chk("btn2_page1", {value_choice, seat_x_o, seat_y_o, vga_btn_o}, {2'd3, 4'd0, 4'd0, 4'd2});
    sample(720, 260, 0, 1, 0, 0);
    chk("btn_gap", {value_choice, seat_x_o, seat_y_o, vga_btn_o}, 0);
    sample(720, 100, 0, 0, 0, 0);
    chk("btn0_page0", {value_choice, vga_btn_o}, {2'd2, 4'd0});
    sample(10, 10, 0, 0, 0, 0);
    chk("blank_corner", {value_choice, seat_x_o, seat_y_o, vga_btn_o}, 0);
    sample(605, 40, 0, 0, 0, 0);
    chk("board_edge_14_0", {value_choice, seat_x_o, seat_y_o, vga_btn_o}, {2'd1, 4'd14, 4'd0, 4'd0});
    sample(606, 40, 0, 0, 0, 0);
    chk("board_miss_606", {value_choice, seat_x_o, seat_y_o, vga_btn_o}, 0);

    // Key interrupt path
    sample(10, 10, 8'h41, 0, 0, 0);
    chk("key_41", {btn_valid_o, overrun_o, btn_o}, {1'b1, 1'b0, 8'h41});
    sample(10, 10, 8'h41, 0, 0, 0);
    chk("key_41_repeat", {btn_valid_o, overrun_o, btn_o}, {1'b1, 1'b0, 8'h41});
    @(negedge clk); btn_ack_i = 1'b1;
    @(negedge clk); btn_ack_i = 1'b0;
    chk("ack_clears", btn_valid_o, 0);
    sample(10, 10, 8'h42, 0, 1, 0);
    chk("event_beats_ack", {btn_valid_o, overrun_o, btn_o}, {1'b1, 1'b0, 8'h42});
    @(negedge clk); btn_ack_i = 1'b1;
    @(negedge clk); btn_ack_i = 1'b0;
    chk("ack_clears_2", btn_valid_o, 0);
    sample(10, 10, 8'h41, 0, 0, 0);
    sample(10, 10, 8'h00, 0, 0, 0);
    chk("release_no_change", {btn_valid_o, overrun_o, btn_o}, {1'b1, 1'b0, 8'h41});
    sample(10, 10, 8'h43, 0, 0, 0);
    chk("overrun", {btn_valid_o, overrun_o, btn_o}, {1'b1, 1'b1, 8'h43});

    // Stray valid while busy must not touch key or position path
    sample(230, 100, 8'h43, 0, 0, 1);
    chk("ignored_busy_pos", {value_choice, seat_x_o, seat_y_o}, {2'd1, 4'd1, 4'd2});
    chk("ignored_busy_key", {btn_o, overrun_o}, {8'h43, 1'b1});
    @(negedge clk); btn_ack_i = 1'b1;
    @(negedge clk); btn_ack_i = 1'b0;
    // 0x44 was never accepted, so prev is still 0x43 and this is no event
    sample(10, 10, 8'h43, 0, 0, 0);
    chk("prev_not_from_busy", btn_valid_o, 0);

    // Reset in the middle of a division
    @(negedge clk);
    x_i = 12'd230; y_i = 12'd100; btn_i = 8'h00; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk); valid_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_p = 1'b1;
    @(negedge clk); rst_p = 1'b0;
    chk("rst_mid_ready", ready_o, 1);
    chk("rst_mid_outs", {out_valid_o, value_choice, seat_x_o, seat_y_o, btn_valid_o, overrun_o, btn_o}, 0);
    ov_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid_o !== 1'b0 || ready_o !== 1'b1) ov_seen++;
    end
    chk("rst_mid_no_pulse", ov_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
